bcd2bin_seq: RTL and testbench
==============================

Name: bcd2bin_seq

Overview:
Sequential BCD-to-binary converter; the inverse of the display-side binary-to-BCD path. Takes a signed BCD entry (magnitude digits plus a sign digit) and produces a two's-complement binary operand for the ALU. Uses one Horner step per clock, acc = acc*10 + digit, most significant digit first, with a start/done handshake and range/digit error reporting.

Parameters:
WIDTH, 12, width of binary result (two's complement)
DIGITS, 4, number of BCD magnitude digits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only in IDLE
bcd  input  4*DIGITS  magnitude digits; bcd[4*DIGITS-1 -: 4] is the most significant digit
bcd_sgn  input  4  sign digit; 4'hA = negative, any other value = positive
bin  output  WIDTH  converted result, registered; held until next completion
busy  output  1  high from the cycle after start is accepted until the cycle done is high, inclusive
done  output  1  one-cycle pulse; bin/err valid and updated in this cycle
err  output  1  registered with done; held until next completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bin=0, busy=0, done=0, err=0; internal acc, count, flags cleared. Deassertion takes effect at the next clk edge.
- Reset mid-conversion aborts the conversion. No done pulse. Outputs return to reset values.
- Internal accumulator: 4*DIGITS bits unsigned. 10^DIGITS-1 < 16^DIGITS, so it never wraps.
- State machine:
  - IDLE: if start=1, capture bcd and bcd_sgn into shadow registers, acc=0, cnt=0, bad=0, go CONV; busy=1 next cycle. If start=0, stay.
  - CONV: d = captured digit [DIGITS-1-cnt]; acc = (acc<<3)+(acc<<1)+d; if d>9 then bad=1 (acc still updated; value is don't-care); cnt++. After DIGITS cycles in CONV go FIN.
  - FIN (one cycle): compute neg = (sgn==4'hA); mag=acc.
    - bad=1: bin=0, err=1.
    - Positive and mag > 2^(WIDTH-1)-1: overflow, err=1, bin per Optional Feature.
    - Negative and mag > 2^(WIDTH-1): overflow, err=1, bin per Optional Feature.
    - Otherwise: err=0, bin = neg ? -mag : mag (truncated to WIDTH). -0 yields 0.
    - done=1, busy=0, go IDLE.
- Latency: start sampled at edge N; bin/err/done updated at edge N+DIGITS+1. Throughput: one conversion per DIGITS+2 cycles; start held high restarts immediately from IDLE.
- start while busy (CONV/FIN) is ignored, not queued. bcd/bcd_sgn changes after capture do not affect the result.
- done deasserts the cycle after FIN regardless of start.

Optional Feature:
Macro BCD2BIN_SAT_EN.
- Defined: on overflow, bin saturates to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative).
- Undefined: on overflow, bin=0.
- err=1 in both builds; invalid-digit handling (bin=0) is unchanged.

Test Plan:
(WIDTH=12, DIGITS=4)
- Reset then bcd=16'h0123, sgn=0, 1-cycle start -> done exactly 5 edges later; bin=12'h07B, err=0; busy high the 5 cycles before and including done.
- bcd=16'h2048, sgn=4'hA -> bin=12'h800, err=0. bcd=16'h2047, sgn=0 -> bin=12'h7FF, err=0. bcd=16'h0000, sgn=4'hA -> bin=0, err=0.
- bcd=16'h2048, sgn=0 -> err=1; bin=12'h7FF with BCD2BIN_SAT_EN, 12'h000 without. bcd=16'h9999, sgn=4'hA -> err=1; bin=12'h800 (SAT) or 0.
- bcd=16'h01B3 (invalid digit) -> err=1, bin=0 in both builds.
- Start, change bcd and pulse start again during CONV -> single done, result of the first captured value. Start held high continuously -> done every 6 cycles.
- Drop rst_n during CONV (cycle 2) -> bin/busy/done/err=0 asynchronously, no done pulse. Release rst_n and start -> normal conversion.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// Sequential signed BCD to two's-complement converter, one Horner step per clock.
// Define BCD2BIN_SAT_EN to saturate on overflow instead of returning zero.
module bcd2bin_seq #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd,
    input  logic [3:0]          bcd_sgn,
    output logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int EW = ((AW > WIDTH) ? AW : WIDTH) + 1;

    localparam logic [EW-1:0] NEG_LIM = EW'(1) << (WIDTH - 1);
    localparam logic [EW-1:0] POS_LIM = NEG_LIM - EW'(1);

`ifdef BCD2BIN_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0]    bcd_sh;
    logic [AW-1:0]    acc;
    logic [3:0]       sgn_q;
    logic [CW-1:0]    cnt;
    logic             bad;

    logic [3:0]       digit;
    logic [AW-1:0]    acc_nxt;
    logic             last;
    logic             accept;
    logic             neg;
    logic [EW-1:0]    mag_e;
    logic [EW-1:0]    neg_e;
    logic             ovf;
    logic [WIDTH-1:0] bin_nxt;
    logic             err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        digit   = bcd_sh[AW-1 -: 4];
        acc_nxt = (acc << 3) + (acc << 1) + AW'(digit);
        last    = (cnt == CW'(DIGITS - 1));
        accept  = (state == IDLE) && start;
        neg     = (sgn_q == 4'hA);
        mag_e   = EW'(acc);
        neg_e   = EW'(0) - mag_e;
        ovf     = neg ? (mag_e > NEG_LIM) : (mag_e > POS_LIM);
        bin_nxt = '0;
        err_nxt = 1'b0;
        // A bad digit outranks overflow: its magnitude is meaningless.
        if (bad) begin
            err_nxt = 1'b1;
        end else if (ovf) begin
            err_nxt = 1'b1;
`ifdef BCD2BIN_SAT_EN
            bin_nxt = neg ? SAT_MIN : SAT_MAX;
`endif
        end else begin
            bin_nxt = neg ? neg_e[WIDTH-1:0] : mag_e[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_sh <= '0;
            acc    <= '0;
            sgn_q  <= '0;
            cnt    <= '0;
            bad    <= 1'b0;
            bin    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                bcd_sh <= bcd;
                sgn_q  <= bcd_sgn;
                acc    <= '0;
                cnt    <= '0;
                bad    <= 1'b0;
                busy   <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (state == CONV) begin
                acc    <= acc_nxt;
                bcd_sh <= bcd_sh << 4;
                cnt    <= cnt + CW'(1);
                if (digit > 4'd9) bad <= 1'b1;
            end
            if (state == FIN) begin
                bin  <= bin_nxt;
                err  <= err_nxt;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq (WIDTH=12, DIGITS=4).
// Expected overflow values follow BCD2BIN_SAT_EN when it is defined.
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd = '0;
    logic [3:0]  bcd_sgn = '0;
    logic [11:0] bin;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd2bin_seq #(.WIDTH(12), .DIGITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd     (bcd),
        .bcd_sgn (bcd_sgn),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

`ifdef BCD2BIN_SAT_EN
    localparam logic [11:0] OVF_POS = 12'h7FF;
    localparam logic [11:0] OVF_NEG = 12'h800;
`else
    localparam logic [11:0] OVF_POS = 12'h000;
    localparam logic [11:0] OVF_NEG = 12'h000;
`endif

    task automatic run_conv(input logic [15:0] b, input logic [3:0] s,
                            input logic [11:0] eb, input logic ee,
                            input string nm);
        @(negedge clk);
        bcd = b;
        bcd_sgn = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcd = ~b;
        bcd_sgn = ~s;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b want 1 0", nm, busy, done);
        end
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b1 || done !== (i == 5)) begin
                errors++;
                $display("FAIL %s edge%0d: busy=%b done=%b want 1 %b",
                         nm, i, busy, done, (i == 5));
            end
        end
        checks++;
        if (bin !== eb || err !== ee) begin
            errors++;
            $display("FAIL %s result: bin=%h err=%b want %h %b",
                     nm, bin, err, eb, ee);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bin !== eb || err !== ee) begin
            errors++;
            $display("FAIL %s after: busy=%b done=%b bin=%h err=%b", nm,
                     busy, done, bin, err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bin !== 12'h000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: bin=%h busy=%b done=%b err=%b want 0",
                     bin, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_values;
        run_conv(16'h0123, 4'h0, 12'h07B, 1'b0, "pos123");
        run_conv(16'h2048, 4'hA, 12'h800, 1'b0, "neg2048");
        run_conv(16'h2047, 4'h0, 12'h7FF, 1'b0, "pos2047");
        run_conv(16'h0000, 4'hA, 12'h000, 1'b0, "negzero");
        run_conv(16'h0005, 4'hA, 12'hFFB, 1'b0, "neg5");
        run_conv(16'h2048, 4'h0, OVF_POS, 1'b1, "ovfpos");
        run_conv(16'h9999, 4'hA, OVF_NEG, 1'b1, "ovfneg");
        run_conv(16'h01B3, 4'h0, 12'h000, 1'b1, "baddig");
        run_conv(16'h0F00, 4'hA, 12'h000, 1'b1, "baddigneg");
    endtask

    task automatic test_ignore_start;
        @(negedge clk);
        bcd = 16'h0456;
        bcd_sgn = 4'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcd = 16'h0999;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 3; i <= 12; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== (i == 5)) begin
                errors++;
                $display("FAIL ignore edge%0d: done=%b want %b", i, done, (i == 5));
            end
            if (i == 5) begin
                checks++;
                if (bin !== 12'h1C8 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore result: bin=%h err=%b want 1c8 0", bin, err);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bcd = 16'h0123;
        bcd_sgn = 4'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== ((i % 6) == 5) || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b edge%0d: done=%b busy=%b want %b 1",
                         i, done, busy, ((i % 6) == 5));
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bin !== 12'h07B) begin
            errors++;
            $display("FAIL b2b drain: busy=%b bin=%h want 0 07b", busy, bin);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bcd = 16'h0777;
        bcd_sgn = 4'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bin !== 12'h000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset: bin=%h busy=%b done=%b err=%b want 0",
                     bin, busy, done, err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset idle%0d: done=%b busy=%b want 0 0",
                         i, done, busy);
            end
        end
        run_conv(16'h0321, 4'h0, 12'h141, 1'b0, "postreset");
    endtask

    initial begin
        test_reset();
        test_values();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
